// File: rtl/ahb_pwm_pkg.sv
// ahb_pwm_pkg: shared constants and types for the AHB PWM register bank.
//   - AHB transfer/response/size codes
//   - region bases and control-register offsets (byte offsets in the slave window)
//   - ID magic, bus FSM state enum, register-kind enum and the address decoder
package ahb_pwm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] REGION_FREQ    = 32'h000;
    localparam logic [31:0] REGION_PNUM    = 32'h100;
    localparam logic [31:0] REGION_PNUMCNT = 32'h200;
    localparam logic [31:0] REGION_CTRL    = 32'h300;

    localparam logic [31:0] OFF_START    = 32'h300;
    localparam logic [31:0] OFF_STOP     = 32'h304;
    localparam logic [31:0] OFF_STATE    = 32'h308;
    localparam logic [31:0] OFF_GPIO_OUT = 32'h30C;
    localparam logic [31:0] OFF_GPIO_SET = 32'h310;
    localparam logic [31:0] OFF_GPIO_CLR = 32'h314;
    localparam logic [31:0] OFF_GPIO_IN  = 32'h318;
    localparam logic [31:0] OFF_LIMIT_L  = 32'h31C;
    localparam logic [31:0] OFF_LIMIT_R  = 32'h320;
    localparam logic [31:0] OFF_ID       = 32'h324;

    localparam logic [15:0] ID_MAGIC = 16'h5057;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr1,
        StErr2
    } ahb_state_e;

    typedef enum logic [3:0] {
        RegNone,
        RegFreq,
        RegPnum,
        RegPnumcnt,
        RegStart,
        RegStop,
        RegState,
        RegGpioOut,
        RegGpioSet,
        RegGpioClr,
        RegGpioIn,
        RegLimitL,
        RegLimitR,
        RegId
    } reg_kind_e;

    // Maps a byte offset to the register it selects; RegNone when unmapped.
    // Alignment is not checked here: control offsets only match exactly, and the
    // bus interface rejects misaligned channel-region accesses.
    function automatic reg_kind_e decode_reg(input logic [31:0] off, input int unsigned nch);
        reg_kind_e kind;
        logic      in_range;
        logic [31:0] region;
        in_range = ({26'd0, off[7:2]} < nch);
        region   = {off[31:8], 8'h00};
        kind     = RegNone;
        if (region == REGION_FREQ) begin
            if (in_range) kind = RegFreq;
        end else if (region == REGION_PNUM) begin
            if (in_range) kind = RegPnum;
        end else if (region == REGION_PNUMCNT) begin
            if (in_range) kind = RegPnumcnt;
        end else if (region == REGION_CTRL) begin
            case (off)
                OFF_START:    kind = RegStart;
                OFF_STOP:     kind = RegStop;
                OFF_STATE:    kind = RegState;
                OFF_GPIO_OUT: kind = RegGpioOut;
                OFF_GPIO_SET: kind = RegGpioSet;
                OFF_GPIO_CLR: kind = RegGpioClr;
                OFF_GPIO_IN:  kind = RegGpioIn;
                OFF_LIMIT_L:  kind = RegLimitL;
                OFF_LIMIT_R:  kind = RegLimitR;
                OFF_ID:       kind = RegId;
                default:      kind = RegNone;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/ahb_lite_slave_if.sv
// ahb_lite_slave_if: AHB-Lite slave front end for the PWM register bank.
// Captures the address phase, classifies it legal/illegal, runs the two-cycle
// ERROR response FSM and hands a one-cycle write/read enable to the register file.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_hsel..i_hready      AHB address-phase inputs, i_hwdata data-phase write data
//   i_addr_mapped         register file says i_haddr selects a mapped register
//   o_hreadyout, o_hresp  AHB response
//   o_wr_en, o_rd_en      legal write/read data phase in progress
//   o_reg_addr, o_wdata   registered data-phase address and the write data
module ahb_lite_slave_if
    import ahb_pwm_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hsel,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic [31:0]       i_hwdata,
    input  logic              i_hready,
    input  logic              i_addr_mapped,
    output logic              o_hreadyout,
    output logic              o_hresp,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [31:0]       o_wdata
);

    ahb_state_e        r_state;
    ahb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              w_accept;
    logic              w_legal;

    // ERR1 drives hready low, so nothing can be accepted there; the extra term keeps
    // the captured address consistent even if a master ignores that.
    assign w_accept = i_hsel & i_hready & (r_state != StErr1) &
                      ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));
    assign w_legal  = (i_hsize == HSIZE_WORD) & (i_haddr[1:0] == 2'b00) & i_addr_mapped;

    always_comb begin
        w_state_nxt = StIdle;
        case (r_state)
            StErr1:  w_state_nxt = StErr2;
            default: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? StData : StErr1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= i_haddr;
                r_write <= i_hwrite;
            end
        end
    end

    // Reset overrides the response combinationally so the bus is released in the
    // very cycle rst is sampled, and any pending write is dropped.
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = HRESP_OKAY;
        o_wr_en     = 1'b0;
        o_rd_en     = 1'b0;
        if (!i_rst) begin
            o_hreadyout = (r_state != StErr1);
            o_hresp     = ((r_state == StErr1) || (r_state == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
            o_wr_en     = (r_state == StData) & r_write;
            o_rd_en     = (r_state == StData) & ~r_write;
        end
    end

    assign o_reg_addr = r_addr;
    assign o_wdata    = i_hwdata;

endmodule

// File: rtl/ahb_pwm_regbank.sv
// ahb_pwm_regbank: AHB-Lite register bank for the multi-axis PWM/pulse controller.
// Ports:
//   clk100m, rst                      clock, synchronous active-high reset
//   hsel..hready, hreadyout/hresp/hrdata  AHB-Lite slave port
//   freq                              per-channel frequency, channel i at [i*FREQ_W +: FREQ_W]
//   pnum_load, pnum_val               one-cycle pulse-count load strobe and its value
//   pwm_start, pwm_stop               one-cycle start/stop strobes
//   gpio_out, gpio_in                 GPIO output register and inputs
//   limit_l, limit_r, pwm_state       per-channel status inputs
//   pnumcnt                           pulses remaining, channel i at [i*CNT_W +: CNT_W]
module ahb_pwm_regbank
    import ahb_pwm_pkg::*;
#(
    parameter int unsigned NCH    = 16,
    parameter int unsigned FREQ_W = 32,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned GPIO_W = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                  clk100m,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [NCH*FREQ_W-1:0] freq,
    output logic [NCH-1:0]        pnum_load,
    output logic [31:0]           pnum_val,
    output logic [NCH-1:0]        pwm_start,
    output logic [NCH-1:0]        pwm_stop,
    output logic [GPIO_W-1:0]     gpio_out,
    input  logic [GPIO_W-1:0]     gpio_in,
    input  logic [NCH-1:0]        limit_l,
    input  logic [NCH-1:0]        limit_r,
    input  logic [NCH-1:0]        pwm_state,
    input  logic [NCH*CNT_W-1:0]  pnumcnt
);

    logic                         w_addr_mapped;
    logic                         w_wr_en;
    logic                         w_rd_en;
    logic [ADDR_W-1:0]            w_reg_addr;
    logic [31:0]                  w_wdata;
    logic [31:0]                  w_doff;
    logic [5:0]                   w_didx;
    reg_kind_e                    w_dkind;
    logic [31:0]                  w_rdata;

    logic [NCH-1:0][FREQ_W-1:0]   r_freq;
    logic [NCH-1:0]               r_pnum_load;
    logic [31:0]                  r_pnum_val;
    logic [NCH-1:0]               r_start;
    logic [NCH-1:0]               r_stop;
    logic [GPIO_W-1:0]            r_gpio;

    // Address-phase decode feeds the legality check; data-phase decode selects the register.
    assign w_addr_mapped = (decode_reg(32'(haddr), NCH) != RegNone);
    assign w_doff        = 32'(w_reg_addr);
    assign w_didx        = w_doff[7:2];
    assign w_dkind       = decode_reg(w_doff, NCH);

    ahb_lite_slave_if #(
        .ADDR_W (ADDR_W)
    ) u_slave_if (
        .i_clk         (clk100m),
        .i_rst         (rst),
        .i_hsel        (hsel),
        .i_haddr       (haddr),
        .i_htrans      (htrans),
        .i_hwrite      (hwrite),
        .i_hsize       (hsize),
        .i_hwdata      (hwdata),
        .i_hready      (hready),
        .i_addr_mapped (w_addr_mapped),
        .o_hreadyout   (hreadyout),
        .o_hresp       (hresp),
        .o_wr_en       (w_wr_en),
        .o_rd_en       (w_rd_en),
        .o_reg_addr    (w_reg_addr),
        .o_wdata       (w_wdata)
    );

    // Writes commit at the edge ending the data phase; strobes are high for the
    // following cycle only.
    always_ff @(posedge clk100m) begin
        if (rst) begin
            r_freq      <= '0;
            r_pnum_load <= '0;
            r_pnum_val  <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_gpio      <= '0;
        end else begin
            r_pnum_load <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            if (w_wr_en) begin
                case (w_dkind)
                    RegFreq: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (w_didx == 6'(i)) r_freq[i] <= w_wdata[FREQ_W-1:0];
                        end
                    end
                    RegPnum: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (w_didx == 6'(i)) r_pnum_load[i] <= 1'b1;
                        end
                        r_pnum_val <= w_wdata;
                    end
                    RegStart:   r_start <= w_wdata[NCH-1:0];
                    RegStop:    r_stop  <= w_wdata[NCH-1:0];
                    RegGpioOut: r_gpio  <= w_wdata[GPIO_W-1:0];
                    RegGpioSet: r_gpio  <= r_gpio | w_wdata[GPIO_W-1:0];
                    RegGpioClr: r_gpio  <= r_gpio & ~w_wdata[GPIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux; write-only registers read as zero, live inputs are sampled now.
    always_comb begin
        w_rdata = '0;
        if (w_rd_en) begin
            case (w_dkind)
                RegFreq: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (w_didx == 6'(i)) w_rdata = 32'(r_freq[i]);
                    end
                end
                RegPnumcnt: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (w_didx == 6'(i)) w_rdata = 32'(pnumcnt[i*CNT_W +: CNT_W]);
                    end
                end
                RegState:   w_rdata = 32'(pwm_state);
                RegGpioOut: w_rdata = 32'(r_gpio);
                RegGpioIn:  w_rdata = 32'(gpio_in);
                RegLimitL:  w_rdata = 32'(limit_l);
                RegLimitR:  w_rdata = 32'(limit_r);
                RegId:      w_rdata = {ID_MAGIC, 8'(NCH), 8'(CNT_W)};
                default:    w_rdata = '0;
            endcase
        end
    end

    assign hrdata    = w_rdata;
    assign freq      = r_freq;
    assign pnum_load = r_pnum_load;
    assign pnum_val  = r_pnum_val;
    assign pwm_start = r_start;
    assign pwm_stop  = r_stop;
    assign gpio_out  = r_gpio;

endmodule

// File: tb/tb_ahb_pwm_regbank.sv
// Testbench for ahb_pwm_regbank: pipelined AHB master with a response scoreboard,
// a strobe monitor and a small register model.
`timescale 1ns/1ps
module tb_ahb_pwm_regbank;

    localparam int NCH    = 16;
    localparam int FREQ_W = 32;
    localparam int CNT_W  = 24;
    localparam int GPIO_W = 32;
    localparam int ADDR_W = 12;

    logic                  clk100m = 1'b0;
    logic                  rst;
    logic                  hsel;
    logic [ADDR_W-1:0]     haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [31:0]           hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [31:0]           hrdata;
    logic [NCH*FREQ_W-1:0] freq;
    logic [NCH-1:0]        pnum_load;
    logic [31:0]           pnum_val;
    logic [NCH-1:0]        pwm_start;
    logic [NCH-1:0]        pwm_stop;
    logic [GPIO_W-1:0]     gpio_out;
    logic [GPIO_W-1:0]     gpio_in;
    logic [NCH-1:0]        limit_l;
    logic [NCH-1:0]        limit_r;
    logic [NCH-1:0]        pwm_state;
    logic [NCH*CNT_W-1:0]  pnumcnt;

    // Single-slave bus: the slave's own ready is the bus ready.
    assign hready = hreadyout;

    always #5 clk100m = ~clk100m;

    ahb_pwm_regbank #(
        .NCH    (NCH),
        .FREQ_W (FREQ_W),
        .CNT_W  (CNT_W),
        .GPIO_W (GPIO_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk100m   (clk100m),
        .rst       (rst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .freq      (freq),
        .pnum_load (pnum_load),
        .pnum_val  (pnum_val),
        .pwm_start (pwm_start),
        .pwm_stop  (pwm_stop),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .limit_l   (limit_l),
        .limit_r   (limit_r),
        .pwm_state (pwm_state),
        .pnumcnt   (pnumcnt)
    );

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        err;
    } tx_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [11:0] addr;
    } exp_t;

    tx_t  q_tx[$];
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_freq [NCH];
    logic [31:0] m_gpio;
    logic [23:0] cnt_val [NCH];

    // Strobe monitor: counts cycles each strobe is non-zero and remembers the value.
    int          n_load = 0;
    int          n_start = 0;
    int          n_stop = 0;
    logic [15:0] last_load;
    logic [31:0] last_pval;
    logic [15:0] last_start;
    logic [15:0] last_stop;

    always @(negedge clk100m) begin
        if (pnum_load != '0) begin
            n_load    = n_load + 1;
            last_load = pnum_load;
            last_pval = pnum_val;
        end
        if (pwm_start != '0) begin
            n_start    = n_start + 1;
            last_start = pwm_start;
        end
        if (pwm_stop != '0) begin
            n_stop    = n_stop + 1;
            last_stop = pwm_stop;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a < 12'h040) return m_freq[a[5:2]];
        if (a >= 12'h200 && a < 12'h240) return {8'h00, cnt_val[a[5:2]]};
        case (a)
            12'h308: return {16'h0000, pwm_state};
            12'h30C: return m_gpio;
            12'h318: return gpio_in;
            12'h31C: return {16'h0000, limit_l};
            12'h320: return {16'h0000, limit_r};
            12'h324: return 32'h5057_1018;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        if (a < 12'h040) m_freq[a[5:2]] = d;
        else if (a == 12'h30C) m_gpio = d;
        else if (a == 12'h310) m_gpio = m_gpio | d;
        else if (a == 12'h314) m_gpio = m_gpio & ~d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_freq[i] = '0;
        m_gpio = '0;
    endtask

    function automatic logic [NCH*FREQ_W-1:0] model_freq_flat();
        logic [NCH*FREQ_W-1:0] f;
        for (int i = 0; i < NCH; i++) f[i*FREQ_W +: FREQ_W] = m_freq[i];
        return f;
    endfunction

    task automatic bus_idle();
        hsel   = 1'b0;
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
    endtask

    task automatic push(input logic [11:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] d, input logic err);
        tx_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.data = d; t.err = err;
        q_tx.push_back(t);
    endtask

    // Pipelined master: drives queued transfers back to back, pushes the expected
    // response when an address phase is accepted and checks it in the data phase.
    // Entered and left just after a rising edge.
    task automatic run_q();
        int          budget;
        bit          acc;
        bit          in_err2;
        tx_t         t;
        exp_t        e;
        logic [33:0] want;
        logic [33:0] got;
        budget  = 0;
        in_err2 = 1'b0;
        while ((q_tx.size() != 0 || sb.size() != 0) && budget < 200) begin
            if (q_tx.size() != 0) begin
                t      = q_tx[0];
                hsel   = 1'b1;
                haddr  = t.addr;
                htrans = 2'b10;
                hwrite = t.wr;
                hsize  = t.size;
            end else begin
                bus_idle();
            end
            hwdata = (sb.size() != 0) ? sb[0].wdata : 32'hDEAD_BEEF;
            @(negedge clk100m);
            if (sb.size() != 0) begin
                e = sb[0];
                if (e.err && !in_err2) want = {2'b01, 32'h0};
                else if (e.err)        want = {2'b11, 32'h0};
                else                   want = {2'b10, (e.wr ? 32'h0 : e.rdata)};
            end else begin
                e.addr = '0;
                want   = {2'b10, 32'h0};
            end
            got = {hreadyout, hresp, hrdata};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL resp@%h: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         e.addr, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
            end
            acc = hreadyout && (q_tx.size() != 0);
            if (sb.size() != 0) begin
                if (sb[0].err && !in_err2) begin
                    in_err2 = 1'b1;
                end else begin
                    void'(sb.pop_front());
                    in_err2 = 1'b0;
                end
            end
            if (acc) begin
                t       = q_tx.pop_front();
                e.wr    = t.wr;
                e.err   = t.err;
                e.wdata = t.data;
                e.addr  = t.addr;
                e.rdata = t.wr ? 32'h0 : model_read(t.addr);
                if (t.wr && !t.err) model_write(t.addr, t.data);
                sb.push_back(e);
            end
            @(posedge clk100m);
            #1;
            budget++;
        end
        bus_idle();
        if (budget >= 200) begin
            n_err++;
            $display("FAIL run_q: cycle budget expired, %0d tx and %0d responses left (want 0)",
                     q_tx.size(), sb.size());
            q_tx.delete();
            sb.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        bus_idle();
        repeat (n) @(posedge clk100m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk100m);
        #1;
        rst = 1'b0;
        @(negedge clk100m);
        n_vec++;
        if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL reset_bus: got rdy=%b resp=%b rdata=%h want 1 0 0", hreadyout, hresp, hrdata);
        end
        n_vec++;
        if (freq !== '0 || gpio_out !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got freq=%h gpio=%h want 0", freq, gpio_out);
        end
        n_vec++;
        if ({pnum_load, pnum_val, pwm_start, pwm_stop} !== '0) begin
            n_err++;
            $display("FAIL reset_strobes: got load=%h val=%h start=%h stop=%h want 0",
                     pnum_load, pnum_val, pwm_start, pwm_stop);
        end
        model_reset();
        @(posedge clk100m);
        #1;
    endtask

    task automatic test_id();
        push(12'h324, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h308, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h31C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h320, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h214, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h23C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h300, 1'b0, 3'b010, 32'h0, 1'b0);
        run_q();
    endtask

    task automatic test_freq();
        push(12'h00C, 1'b1, 3'b010, 32'h0001_86A0, 1'b0);
        push(12'h00C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h000, 1'b1, 3'b010, 32'hCAFE_0001, 1'b0);
        push(12'h03C, 1'b1, 3'b010, 32'h8000_0000, 1'b0);
        push(12'h03C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h000, 1'b0, 3'b010, 32'h0, 1'b0);
        run_q();
        n_vec++;
        if (freq[3*FREQ_W +: FREQ_W] !== 32'h0001_86A0) begin
            n_err++;
            $display("FAIL freq3_out: got %h want 000186a0", freq[3*FREQ_W +: FREQ_W]);
        end
        n_vec++;
        if (freq !== model_freq_flat()) begin
            n_err++;
            $display("FAIL freq_all: got %h want %h", freq, model_freq_flat());
        end
    endtask

    task automatic test_strobes();
        int l0;
        int s0;
        int p0;
        l0 = n_load; s0 = n_start; p0 = n_stop;
        push(12'h13C, 1'b1, 3'b010, 32'd1000, 1'b0);
        run_q();
        idle_cycles(3);
        n_vec++;
        if (n_load - l0 != 1 || last_load !== 16'h8000 || last_pval !== 32'd1000) begin
            n_err++;
            $display("FAIL pnum_load: got cycles=%0d load=%h val=%0d want 1 8000 1000",
                     n_load - l0, last_load, last_pval);
        end
        n_vec++;
        if (pnum_val !== 32'd1000 || pnum_load !== '0) begin
            n_err++;
            $display("FAIL pnum_hold: got val=%0d load=%h want 1000 0", pnum_val, pnum_load);
        end
        push(12'h300, 1'b1, 3'b010, 32'h0000_8001, 1'b0);
        push(12'h304, 1'b1, 3'b010, 32'h0000_0001, 1'b0);
        run_q();
        idle_cycles(3);
        n_vec++;
        if (n_start - s0 != 1 || last_start !== 16'h8001) begin
            n_err++;
            $display("FAIL pwm_start: got cycles=%0d value=%h want 1 8001", n_start - s0, last_start);
        end
        n_vec++;
        if (n_stop - p0 != 1 || last_stop !== 16'h0001) begin
            n_err++;
            $display("FAIL pwm_stop: got cycles=%0d value=%h want 1 0001", n_stop - p0, last_stop);
        end
    endtask

    task automatic test_gpio();
        push(12'h30C, 1'b1, 3'b010, 32'h0000_000F, 1'b0);
        push(12'h310, 1'b1, 3'b010, 32'h0000_00F0, 1'b0);
        push(12'h314, 1'b1, 3'b010, 32'h0000_0003, 1'b0);
        push(12'h30C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h318, 1'b0, 3'b010, 32'h0, 1'b0);
        run_q();
        n_vec++;
        if (gpio_out !== 32'h0000_00FC) begin
            n_err++;
            $display("FAIL gpio_out: got %h want 000000fc", gpio_out);
        end
    endtask

    task automatic test_errors();
        push(12'h040, 1'b0, 3'b010, 32'h0, 1'b1);
        push(12'h30C, 1'b1, 3'b000, 32'hFFFF_FFFF, 1'b1);
        push(12'h30C, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h040, 1'b1, 3'b010, 32'h1111_1111, 1'b1);
        push(12'h302, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b1);
        push(12'h328, 1'b0, 3'b010, 32'h0, 1'b1);
        push(12'h140, 1'b1, 3'b010, 32'h5, 1'b1);
        push(12'h324, 1'b0, 3'b010, 32'h0, 1'b0);
        run_q();
        n_vec++;
        if (freq !== model_freq_flat() || gpio_out !== m_gpio) begin
            n_err++;
            $display("FAIL err_no_effect: got gpio=%h freq=%h want gpio=%h freq=%h",
                     gpio_out, freq, m_gpio, model_freq_flat());
        end
    endtask

    task automatic test_back_to_back();
        int          ch;
        logic [31:0] d;
        for (int k = 0; k < 8; k++) begin
            ch = $urandom_range(0, NCH - 1);
            d  = $urandom;
            push(12'(ch * 4), 1'b1, 3'b010, d, 1'b0);
            push(12'(ch * 4), 1'b0, 3'b010, 32'h0, 1'b0);
            push(12'(((ch + 1) % NCH) * 4), 1'b0, 3'b010, 32'h0, 1'b0);
            push(12'h200 + 12'(ch * 4), 1'b0, 3'b010, 32'h0, 1'b0);
            push(12'h310 + 12'((k % 2) * 4), 1'b1, 3'b010, $urandom, 1'b0);
            push(12'h30C, 1'b0, 3'b010, 32'h0, 1'b0);
        end
        run_q();
        n_vec++;
        if (freq !== model_freq_flat() || gpio_out !== m_gpio) begin
            n_err++;
            $display("FAIL b2b_final: got gpio=%h freq=%h want gpio=%h freq=%h",
                     gpio_out, freq, m_gpio, model_freq_flat());
        end
    endtask

    task automatic test_reset_mid();
        int l0;
        push(12'h010, 1'b1, 3'b010, 32'h1234_5678, 1'b0);
        push(12'h30C, 1'b1, 3'b010, 32'h0000_00FF, 1'b0);
        run_q();
        // Illegal read, then reset while the slave sits in ERR1.
        hsel = 1'b1; haddr = 12'h040; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk100m);
        #1;
        bus_idle();
        @(negedge clk100m);
        n_vec++;
        if ({hreadyout, hresp} !== 2'b01) begin
            n_err++;
            $display("FAIL err1_entry: got rdy=%b resp=%b want 0 1", hreadyout, hresp);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({hreadyout, hresp} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_in_err1: got rdy=%b resp=%b want 1 0", hreadyout, hresp);
        end
        @(posedge clk100m);
        #1;
        rst = 1'b0;
        @(negedge clk100m);
        n_vec++;
        if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h0} || freq !== '0 || gpio_out !== '0) begin
            n_err++;
            $display("FAIL after_rst1: got rdy=%b resp=%b rdata=%h gpio=%h freq=%h want 1 0 0 0 0",
                     hreadyout, hresp, hrdata, gpio_out, freq);
        end
        model_reset();
        // PNUM write whose data phase is hit by reset.
        l0 = n_load;
        hsel = 1'b1; haddr = 12'h104; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk100m);
        #1;
        bus_idle();
        hwdata = 32'd777;
        rst    = 1'b1;
        #1;
        n_vec++;
        if ({hreadyout, hresp} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_in_data: got rdy=%b resp=%b want 1 0", hreadyout, hresp);
        end
        @(posedge clk100m);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk100m);
        n_vec++;
        if (n_load != l0 || pnum_load !== '0 || pnum_val !== '0) begin
            n_err++;
            $display("FAIL rst_drop_pnum: got pulses=%0d load=%h val=%h want 0 0 0",
                     n_load - l0, pnum_load, pnum_val);
        end
        @(posedge clk100m);
        #1;
        push(12'h324, 1'b0, 3'b010, 32'h0, 1'b0);
        push(12'h30C, 1'b0, 3'b010, 32'h0, 1'b0);
        run_q();
    endtask

    initial begin
        rst       = 1'b1;
        bus_idle();
        hwdata    = '0;
        gpio_in   = 32'h0000_A5A5;
        limit_l   = 16'h00F1;
        limit_r   = 16'h1F00;
        pwm_state = 16'h0123;
        for (int i = 0; i < NCH; i++) begin
            cnt_val[i] = 24'(32'h01_0000 * i + 32'h33 * i + 5);
            pnumcnt[i*CNT_W +: CNT_W] = cnt_val[i];
        end
        model_reset();

        test_reset();
        test_id();
        test_freq();
        test_strobes();
        test_gpio();
        test_errors();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_pwm_regbank.md
Name: ahb_pwm_regbank

Overview:
Parametrised AHB-Lite slave register bank for the multi-axis PWM/pulse controller. It sits between the M3 AHB bridge master and the per-channel PWM generators.
- Replaces one-hot address-bit decode with word-indexed regions and a variable channel count.
- Adds frequency readback, separate start/stop strobes, GPIO W1S/W1C, and AHB ERROR responses for illegal accesses.

Parameters:
NCH, 16, number of PWM channels (1..32)
FREQ_W, 32, frequency/period register width (1..32)
CNT_W, 24, pulse-remaining counter width (1..32)
GPIO_W, 32, GPIO width (1..32)
ADDR_W, 12, decoded address bits (byte offset within slave window)

Ports:
clk100m  in  1  system/bus clock
rst  in  1  synchronous active-high reset
hsel  in  1  slave select
haddr  in  ADDR_W  byte address
htrans  in  2  AHB transfer type
hwrite  in  1  1=write
hsize  in  3  transfer size
hwdata  in  32  write data (data phase)
hready  in  1  bus ready (address-phase qualifier)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY 1=ERROR
hrdata  out  32  read data (data phase)
freq  out  NCH*FREQ_W  per-channel frequency, channel i at [i*FREQ_W +: FREQ_W]
pnum_load  out  NCH  one-cycle load strobe per channel
pnum_val  out  32  pulse count value accompanying pnum_load
pwm_start  out  NCH  one-cycle start strobes
pwm_stop  out  NCH  one-cycle stop strobes
gpio_out  out  GPIO_W  GPIO output register
gpio_in  in  GPIO_W  GPIO inputs
limit_l  in  NCH  left limit switches
limit_r  in  NCH  right limit switches
pwm_state  in  NCH  channel running flags
pnumcnt  in  NCH*CNT_W  pulses remaining, channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Address map (byte offsets):
  - 0x000+4i FREQ[i] RW
  - 0x100+4i PNUM[i] WO
  - 0x200+4i PNUMCNT[i] RO
  - 0x300 START WO
  - 0x304 STOP WO
  - 0x308 STATE RO
  - 0x30C GPIO_OUT RW
  - 0x310 GPIO_SET W1S
  - 0x314 GPIO_CLR W1C
  - 0x318 GPIO_IN RO
  - 0x31C LIMIT_L RO
  - 0x320 LIMIT_R RO
  - 0x324 ID RO = {16'h5057, NCH[7:0], CNT_W[7:0]}
- Address phase is accepted when hsel & hready & htrans[1]. On acceptance, register haddr, hwrite, and legality.
- Legal access: hsize=3'b010 and haddr[1:0]=0, and a mapped offset. Channel index i must be < NCH. Anything else is illegal.
- Legal write: commits at the clock edge ending the data phase, using that cycle's hwdata. The new value is visible to the next data phase, so back-to-back write then read of the same register returns the new value.
- Writes to RO registers: ignored, respond OKAY.
- Legal read: hrdata is a combinational mux from the registered address during the data phase. Live inputs are sampled in that cycle. Narrow fields are zero-extended. hrdata=0 outside read data phases.
- Zero wait states for all legal transfers: hreadyout=1, hresp=0.
- Illegal transfer produces the two-cycle ERROR response:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - Then IDLE.
  - No register or strobe effect.
  - An address phase presented during ERR2 is accepted normally. During ERR1, hready=0 blocks acceptance.
- FSM states: IDLE (no data phase), DATA (legal data phase), ERR1, ERR2.
  - IDLE/DATA -> DATA on accept of a legal transfer.
  - IDLE/DATA -> ERR1 on accept of an illegal transfer.
  - IDLE/DATA -> IDLE when nothing is accepted.
  - ERR1 -> ERR2.
  - ERR2 -> DATA, ERR1 or IDLE by the same accept rule.
- FREQ[i] write: freq[i] <= hwdata[FREQ_W-1:0].
- PNUM[i] write: pnum_load[i]=1 for exactly one cycle after commit, with pnum_val=hwdata. pnum_val holds its last value otherwise.
- START/STOP write: pwm_start/pwm_stop <= hwdata[NCH-1:0] for one cycle, then 0.
- GPIO_SET: gpio_out |= hwdata. GPIO_CLR: gpio_out &= ~hwdata. GPIO_OUT: direct load.
- Reset values: freq=0, gpio_out=0, pnum_load=0, pnum_val=0, pwm_start=0, pwm_stop=0, hrdata=0, hreadyout=1, hresp=0, FSM=IDLE.
- Reset mid-transfer: the pending write is discarded, strobes are cleared, and hreadyout returns to 1 in the same cycle rst is sampled.

Decomposition:
- Package ahb_pwm_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes, HSIZE_WORD.
  - Region bases (0x000/0x100/0x200/0x300) and all control offsets.
  - The ID magic 16'h5057.
  - The FSM state enum.
- Sub-module ahb_lite_slave_if owns address-phase capture, the legality check input, the ERROR FSM and hreadyout/hresp. It exports wr_en, rd_en, reg_addr and wdata to the register file.

Test Plan:
- Reset, then read ID (NCH=16, CNT_W=24) -> hrdata=32'h5057_1018, OKAY, zero wait.
- Write FREQ[3]=32'h0001_86A0, then read FREQ[3] back-to-back -> hrdata=32'h0001_86A0; freq[3] updates one cycle after the data phase.
- Write PNUM[15]=1000 -> pnum_load=16'h8000 for exactly one cycle with pnum_val=1000. Write START=16'h8001 -> one-cycle pwm_start=16'h8001. Write STOP=1 -> pwm_stop=1.
- GPIO_OUT=0x0F, GPIO_SET=0xF0, GPIO_CLR=0x03 -> gpio_out=0xFC. Read GPIO_IN with gpio_in=0xA5A5 -> 0x0000A5A5.
- Access FREQ[16] (offset 0x040) with NCH=16, then a byte write (hsize=0) to 0x30C:
  - Each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1).
  - freq and gpio_out are unchanged.
  - The following legal read completes OKAY.
- Assert rst during ERR1 and during a PNUM write data phase -> hreadyout=1, hresp=0, no pnum_load pulse, all registers at reset values.
